// File: rtl/count_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_ctrl_pkg : shared types and default widths for the counter controller |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package count_ctrl_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_START = 2'b10,
    OP_STOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/count_ctrl_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_gen : prescaler, pulses tick once every (prescale+1) enabled cycles    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tick_gen
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == prescale);

  // clear has priority so a stop/arm always restarts the divider from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_ctrl : command-driven sequencer for a prescaled WIDTH-bit up-counter  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic                  cfg_periodic,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  output logic [WIDTH-1:0]      val,
  output logic                  busy,
  output logic                  done
);

  state_e                r_state, w_state_nxt;
  logic [WIDTH-1:0]      r_val, w_val_nxt;
  logic [WIDTH-1:0]      r_limit, w_limit_nxt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_periodic;
  logic                  r_done, w_done_nxt;
  logic                  w_latch_cfg;
  logic                  w_clear;
  logic                  w_tick;
  logic                  w_accept;
  op_e                   w_op;

  assign cmd_ready = !rst && (r_state != ST_ARM);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_op      = op_e'(cmd_op);
  assign val       = r_val;
  assign busy      = (r_state == ST_ARM) || (r_state == ST_RUN);
  assign done      = r_done;

  tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .enable   (r_state == ST_RUN),
    .prescale (r_prescale),
    .tick     (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_val_nxt   = r_val;
    w_limit_nxt = r_limit;
    w_done_nxt  = 1'b0;
    w_latch_cfg = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_op == OP_LOAD)) begin
          w_limit_nxt = cmd_data;
        end else if (w_accept && (w_op == OP_START)) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        w_val_nxt   = '0;
        w_clear     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept && (w_op == OP_LOAD)) begin
          w_limit_nxt = cmd_data;
        end
        // STOP/START take precedence over a coincident terminal tick
        if (w_accept && (w_op == OP_STOP)) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_accept && (w_op == OP_START)) begin
          w_latch_cfg = 1'b1;
          w_state_nxt = ST_ARM;
        end else if (w_tick) begin
          if (r_val == r_limit) begin
            w_done_nxt = 1'b1;
            if (r_periodic) begin
              w_val_nxt = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_val_nxt = r_val + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_val      <= '0;
      r_limit    <= '1;
      r_prescale <= '0;
      r_periodic <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_val   <= w_val_nxt;
      r_limit <= w_limit_nxt;
      r_done  <= w_done_nxt;
      if (w_latch_cfg) begin
        r_prescale <= cfg_prescale;
        r_periodic <= cfg_periodic;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_count_ctrl : scoreboard bench for count_ctrl (WIDTH=4, PRESCALE_W=4)     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic       cfg_periodic = 1'b0;
  logic [3:0] cfg_prescale = 4'd0;
  logic [3:0] val;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // one scoreboard entry per clock cycle: {val, busy, done, cmd_ready}
  typedef struct packed {
    logic [3:0] val;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t q[$];

  count_ctrl #(
    .WIDTH      (4),
    .PRESCALE_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cfg_periodic (cfg_periodic),
    .cfg_prescale (cfg_prescale),
    .val          (val),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Present a command for one cycle; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] data,
                       input logic per, input logic [3:0] pre);
    @(negedge clk);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_data     = data;
    cfg_periodic = per;
    cfg_prescale = pre;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  task automatic push(input int v, input logic b, input logic d, input logic r);
    exp_t e;
    e.val   = 4'(v);
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    q.push_back(e);
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({val, busy, done, cmd_ready} !== 7'b0000_000) begin
      errors++;
      $display("FAIL reset_state got val=%0d busy=%b done=%b ready=%b exp 0/0/0/0", val, busy, done, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({val, busy, done, cmd_ready} !== 7'b0000_001) begin
      errors++;
      $display("FAIL reset_release got val=%0d busy=%b done=%b ready=%b exp 0/0/0/1", val, busy, done, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    issue(OP_START, 4'd0, 1'b1, 4'd0);
    repeat (5) @(negedge clk);
    checks++;
    if (val !== 4'd3) begin
      errors++;
      $display("FAIL midrun_pre got val=%0d exp 3", val);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({val, busy, done, cmd_ready} !== 7'b0000_000) begin
      errors++;
      $display("FAIL midrun_async got val=%0d busy=%b done=%b ready=%b exp 0/0/0/0", val, busy, done, cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({val, busy, done, cmd_ready} !== 7'b0000_001) begin
      errors++;
      $display("FAIL midrun_release got val=%0d busy=%b done=%b ready=%b exp 0/0/0/1", val, busy, done, cmd_ready);
    end
  endtask

  task automatic test_oneshot;
    exp_t e;
    issue(OP_LOAD, 4'd5, 1'b0, 4'd0);
    issue(OP_START, 4'd0, 1'b0, 4'd0);
    push(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) push(k, 1'b1, 1'b0, 1'b1);
    push(5, 1'b0, 1'b1, 1'b1);
    push(5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL oneshot[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
  endtask

  task automatic test_periodic_prescale;
    exp_t e;
    issue(OP_LOAD, 4'd3, 1'b0, 4'd0);
    issue(OP_START, 4'd0, 1'b1, 4'd2);
    push(5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++)
      push((k / 3) % 4, 1'b1, (k >= 12) && (k % 12 == 0), 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL periodic[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
    issue(OP_STOP, 4'd0, 1'b0, 4'd0);
    push(2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL periodic_stop got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
  endtask

  task automatic test_stop_on_terminal;
    exp_t e;
    issue(OP_LOAD, 4'd2, 1'b0, 4'd0);
    issue(OP_START, 4'd0, 1'b0, 4'd0);
    push(2, 1'b1, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0, 1'b1);
    push(1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL stopterm_run[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
    issue(OP_STOP, 4'd0, 1'b0, 4'd0);
    push(2, 1'b0, 1'b0, 1'b1);
    push(2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL stopterm_after[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
  endtask

  task automatic test_load_in_run;
    exp_t e;
    issue(OP_LOAD, 4'd9, 1'b0, 4'd0);
    issue(OP_START, 4'd0, 1'b1, 4'd0);
    push(2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 5; k++) push(k, 1'b1, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL loadrun_pre[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
    // LOAD lands while val=6; the new limit 4 is already behind the count
    issue(OP_LOAD, 4'd4, 1'b0, 4'd0);
    for (int k = 7; k <= 15; k++) push(k, 1'b1, 1'b0, 1'b1);
    push(0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) push(k, 1'b1, 1'b0, 1'b1);
    push(0, 1'b1, 1'b1, 1'b1);
    push(1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL loadrun[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
    issue(OP_STOP, 4'd0, 1'b0, 4'd0);
    @(negedge clk);
    checks++;
    if ({val, busy, done} !== {4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL loadrun_stop got val=%0d busy=%b done=%b exp val=2 busy=0 done=0", val, busy, done);
    end
  endtask

  task automatic test_limit_zero;
    exp_t e;
    issue(OP_LOAD, 4'd0, 1'b0, 4'd0);
    issue(OP_START, 4'd0, 1'b0, 4'd0);
    push(2, 1'b1, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0, 1'b1);
    push(0, 1'b0, 1'b1, 1'b1);
    push(0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if ({val, busy, done, cmd_ready} !== e) begin
        errors++;
        $display("FAIL limit0[%0d] got val=%0d busy=%b done=%b ready=%b exp val=%0d busy=%b done=%b ready=%b",
                 i, val, busy, done, cmd_ready, e.val, e.busy, e.done, e.ready);
      end
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_oneshot;
    test_periodic_prescale;
    test_stop_on_terminal;
    test_load_in_run;
    test_limit_zero;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t, bench did not complete", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Command-driven controller that sequences a WIDTH-bit up-counter.
- Accepts LOAD/START/STOP commands over a valid/ready handshake.
- Runs the counter one-shot or auto-reload, through a programmable prescaler.
- Flags each terminal count with a one-cycle pulse.
- Sits between a host/sequencer and the counter datapath; exposes the live count.

Parameters:
WIDTH, 4, counter width; limit and val width.
PRESCALE_W, 4, prescaler width; count advances once every (cfg_prescale+1) RUN cycles.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command this cycle.
cmd_op  input  2  00 NOP, 01 LOAD, 10 START, 11 STOP.
cmd_data  input  WIDTH  terminal value for LOAD; ignored otherwise.
cfg_periodic  input  1  1 = auto-reload, 0 = one-shot; sampled when START is accepted.
cfg_prescale  input  PRESCALE_W  prescale divisor minus 1; sampled when START is accepted.
val  output  WIDTH  current count.
busy  output  1  high in ARM and RUN.
done  output  1  one-cycle pulse after each terminal tick.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, val 0, limit all-ones, prescale register 0, periodic register 0.
  - done 0, busy 0, cmd_ready 0 while rst is high.
  - Reset mid-RUN clears val immediately; no done pulse.
- Accept rule: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_ready does not depend on cmd_valid or cmd_op.
- cmd_ready: 1 in IDLE and RUN, 0 in ARM.
- States:
  - IDLE: val holds its last value.
    - LOAD: limit <= cmd_data.
    - START: latch cfg_periodic and cfg_prescale; go to ARM.
    - STOP and NOP have no effect.
  - ARM (exactly 1 cycle): val <= 0, prescaler <= 0; go to RUN.
  - RUN: the prescaler counts 0..prescale.
    - tick = (prescaler == prescale); the prescaler wraps to 0 on tick.
    - On a non-terminal tick: val <= val + 1, wrapping modulo 2^WIDTH with no done.
    - Terminal tick = tick && val == limit.
      - periodic: val <= 0, stay in RUN.
      - one-shot: val holds limit, go to IDLE.
    - done is registered and high the cycle after every terminal tick.
- Commands in RUN:
  - STOP: go to IDLE next cycle, val frozen, prescaler cleared.
  - START: restart; re-latch config and go to ARM.
  - LOAD: limit updates next cycle, counting continues.
    - If the new limit is below val, the count wraps through 2^WIDTH-1 to 0 before terminating.
- Simultaneous events: STOP or START accepted on the same edge as a terminal tick wins; that tick produces no done and no reload.
- Latency with prescale p, START accepted at edge N:
  - ARM in cycle N+1; val = 0 in cycle N+2.
  - First increment at the end of cycle N+2+p.
  - For limit L, done is high in cycle N+3+(L+1)(p+1)-1.
- limit 0: the terminal tick is the first tick. One-shot gives done at N+3+p; periodic gives done every p+1 cycles.

Decomposition:
- Package count_ctrl_pkg:
  - op enum (OP_NOP, OP_LOAD, OP_START, OP_STOP).
  - state enum (ST_IDLE, ST_ARM, ST_RUN).
  - width localparams.
- Sub-module tick_gen (prescaler):
  - Inputs: clk, rst, clear, enable, prescale.
  - Output: tick.
- count_ctrl holds the FSM, limit/config registers, val and done.

Test Plan:
1. Reset during RUN with val=3 -> val=0, busy=0, done=0 while rst is high, without waiting for a clk edge; after release cmd_ready=1 and state is IDLE.
2. LOAD 5, then START one-shot, prescale 0, accepted at edge N -> cmd_ready=0 in N+1; val=0,1,2,3,4,5 in cycles N+2..N+7; done=1 only in N+8; busy=0 from N+8; val holds 5.
3. LOAD 3, START periodic, prescale 2 -> val increments every 3 cycles: 0,1,2,3,0,...; done pulses once every 12 cycles, in the cycle after each 3->0 wrap.
4. STOP issued on the same edge as the terminal tick (limit 2, one-shot) -> no done pulse; state IDLE; val frozen at 2.
5. Periodic run with limit 9 and val=6; LOAD 4 in RUN -> count continues 7..15, wraps to 0 with no done, then terminates at 4 with done.
6. LOAD 0, START one-shot, prescale 0 -> done at N+3; val=0 throughout; back to IDLE.
